// File: rtl/temporizador_pkg.sv
// Shared definitions for the multi-channel millisecond timer.
//   - default values for the channel count, count width and prescale ratio
//   - per-channel state encoding (idle / running)
package temporizador_pkg;

  localparam int unsigned N_CH_DEFAULT     = 4;
  localparam int unsigned W_DEFAULT        = 16;
  localparam int unsigned PRESCALE_DEFAULT = 100000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

endpackage

// File: rtl/temporizador_prescaler.sv
// Free-running prescaler shared by all timer channels.
// Counts 0..PRESCALE-1 and asserts tick for the one clock in which the count
// sits at PRESCALE-1; the count then wraps to 0.
// Ports:
//   clk_100MHz : system clock
//   rst        : asynchronous active-high reset (count cleared to 0)
//   tick       : one-clock strobe, once every PRESCALE clocks
module temporizador_prescaler
  import temporizador_pkg::*;
#(
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk_100MHz,
  input  logic rst,
  output logic tick
);

  localparam int unsigned     CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = w_last;

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/temporizador_multi.sv
// Multi-channel down-counting timer driven by one shared millisecond tick.
// Each channel is loaded by a start strobe, decrements once per tick while
// running, and emits a one-clock expiry pulse when it reaches zero; periodic
// channels reload the value latched at start and keep running.
// Ports:
//   clk_100MHz  : system clock
//   rst         : asynchronous active-high reset
//   start_timer : per-channel start/restart strobe
//   stop_timer  : per-channel abort strobe (wins over start and tick)
//   value       : per-channel load value, channel i at [i*W +: W]
//   periodic    : per-channel mode, 0 = one-shot, 1 = auto-reload
//   texpired    : per-channel one-clock expiry pulse (registered)
//   busy        : per-channel running flag (registered)
//   remaining   : per-channel current count, same packing as value
module temporizador_multi
  import temporizador_pkg::*;
#(
  parameter int unsigned N_CH     = N_CH_DEFAULT,
  parameter int unsigned W        = W_DEFAULT,
  parameter int unsigned PRESCALE = PRESCALE_DEFAULT
) (
  input  logic                clk_100MHz,
  input  logic                rst,
  input  logic [N_CH-1:0]     start_timer,
  input  logic [N_CH-1:0]     stop_timer,
  input  logic [N_CH*W-1:0]   value,
  input  logic [N_CH-1:0]     periodic,
  output logic [N_CH-1:0]     texpired,
  output logic [N_CH-1:0]     busy,
  output logic [N_CH*W-1:0]   remaining
);

  localparam logic [W-1:0] ONE = W'(1);

  logic w_tick;

  temporizador_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .tick       (w_tick)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_t      r_state;
    logic [W-1:0]   r_count;
    logic [W-1:0]   r_reload;
    logic           r_periodic;
    logic           r_exp;
    logic [W-1:0]   w_val;

    assign w_val = value[i*W +: W];

    // Priority: stop > start > tick. A zero-valued start is an immediate
    // expiry and never enters RUN, so a running count is always >= 1.
    always_ff @(posedge clk_100MHz or posedge rst) begin
      if (rst) begin
        r_state    <= ST_IDLE;
        r_count    <= '0;
        r_reload   <= '0;
        r_periodic <= 1'b0;
        r_exp      <= 1'b0;
      end else begin
        r_exp <= 1'b0;
        if (stop_timer[i]) begin
          r_state <= ST_IDLE;
          r_count <= '0;
        end else if (start_timer[i]) begin
          if (w_val != '0) begin
            r_state    <= ST_RUN;
            r_count    <= w_val;
            r_reload   <= w_val;
            r_periodic <= periodic[i];
          end else begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_exp   <= 1'b1;
          end
        end else if (r_state == ST_RUN && w_tick) begin
          if (r_count == ONE) begin
            r_exp <= 1'b1;
            if (r_periodic) begin
              r_count <= r_reload;
            end else begin
              r_count <= '0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_count <= r_count - ONE;
          end
        end
      end
    end

    assign texpired[i]         = r_exp;
    assign busy[i]             = (r_state == ST_RUN);
    assign remaining[i*W +: W] = r_count;
  end

endmodule

// File: tb/tb_temporizador_multi.sv
module tb_temporizador_multi;

  logic        clk_100MHz;
  logic        rst;
  logic [3:0]  start_timer;
  logic [3:0]  stop_timer;
  logic [31:0] value;
  logic [3:0]  periodic;
  logic [3:0]  texpired;
  logic [3:0]  busy;
  logic [31:0] remaining;

  temporizador_multi #(
    .N_CH     (4),
    .W        (8),
    .PRESCALE (4)
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .rst         (rst),
    .start_timer (start_timer),
    .stop_timer  (stop_timer),
    .value       (value),
    .periodic    (periodic),
    .texpired    (texpired),
    .busy        (busy),
    .remaining   (remaining)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [31:0] val;
    logic [3:0]  per;
    logic [3:0]  exp_texp;
    logic [3:0]  exp_busy;
    logic [31:0] exp_rem;
  } vec_t;

  vec_t tbl [13];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          edge_n = 0;
  int          pulses;

  task automatic step();
    @(posedge clk_100MHz);
    #1;
    edge_n++;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (edge %0d): got %h, expected %h", nm, edge_n, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] st, input logic [3:0] sp,
                       input logic [31:0] v, input logic [3:0] p);
    start_timer = st;
    stop_timer  = sp;
    value       = v;
    periodic    = p;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0, 4'b0, 32'h0, 4'b0);
    repeat (2) @(posedge clk_100MHz);
    #1;
    rst    = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // start, stop, value, periodic | texpired, busy, remaining ({ch3,ch2,ch1,ch0})
    tbl[0]  = '{4'b0001, 4'b0000, 32'h0000_0003, 4'b0000, 4'b0000, 4'b0001, 32'h0000_0003};
    tbl[1]  = '{4'b1000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b1000, 4'b0001, 32'h0000_0003};
    tbl[2]  = '{4'b0100, 4'b0000, 32'h0005_0000, 4'b0000, 4'b0000, 4'b0101, 32'h0005_0003};
    tbl[3]  = '{4'b0010, 4'b0000, 32'h0000_0200, 4'b0000, 4'b0000, 4'b0111, 32'h0004_0202};
    tbl[4]  = '{4'b0010, 4'b0010, 32'h0000_0700, 4'b0000, 4'b0000, 4'b0101, 32'h0004_0002};
    tbl[5]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0101, 32'h0004_0002};
    tbl[6]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0101, 32'h0004_0002};
    tbl[7]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0101, 32'h0003_0001};
    tbl[8]  = '{4'b0000, 4'b0100, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0001, 32'h0000_0001};
    tbl[9]  = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0001, 32'h0000_0001};
    tbl[10] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0001, 32'h0000_0001};
    tbl[11] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0001, 4'b0000, 32'h0000_0000};
    tbl[12] = '{4'b0000, 4'b0000, 32'h0000_0000, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000};

    do_reset();
    chk("reset_state", 64'({texpired, busy, remaining}), 64'h0);

    // One-shot ch0, zero load ch3, stop ch2, tick-aligned start and stop+start on ch1
    for (int k = 0; k < 13; k++) begin
      drive(tbl[k].start, tbl[k].stop, tbl[k].val, tbl[k].per);
      step();
      chk($sformatf("table_row%0d", k), 64'({texpired, busy, remaining}),
          64'({tbl[k].exp_texp, tbl[k].exp_busy, tbl[k].exp_rem}));
    end

    // Periodic ch1, reload 2: pulses on every 8th edge; later input changes ignored
    do_reset();
    pulses = 0;
    drive(4'b0010, 4'b0000, 32'h0000_0200, 4'b0010);
    step();
    chk("per_load", 64'({busy[1], remaining[15:8]}), 64'h102);
    drive(4'b0000, 4'b0000, 32'h0000_0900, 4'b0000);
    for (int e = 2; e <= 41; e++) begin
      step();
      chk("per_exp", 64'(texpired[1]), 64'((e % 8) == 0));
      chk("per_busy", 64'(busy[1]), 64'h1);
      if (texpired[1]) pulses++;
    end
    chk("per_count", 64'(pulses), 64'd5);
    drive(4'b0000, 4'b0010, 32'h0, 4'b0);
    step();
    chk("per_stop", 64'({texpired[1], busy[1], remaining[15:8]}), 64'h0);

    // Restart ch0 mid-run with 4: expiry on 4th tick after restart (edge 20)
    do_reset();
    for (int e = 1; e <= 22; e++) begin
      if (e == 1)      drive(4'b0001, 4'b0000, 32'h0000_0003, 4'b0000);
      else if (e == 6) drive(4'b0001, 4'b0000, 32'h0000_0004, 4'b0000);
      else             drive(4'b0000, 4'b0000, 32'h0000_0000, 4'b0000);
      step();
      if (e == 5) chk("restart_pre", 64'(remaining[7:0]), 64'd2);
      if (e == 6) chk("restart_load", 64'({busy[0], remaining[7:0]}), 64'h104);
      chk("restart_exp", 64'(texpired[0]), 64'(e == 20));
    end

    // Asynchronous reset with all channels running; strobes ignored while rst high
    drive(4'b1111, 4'b0000, 32'h0505_0505, 4'b0000);
    step();
    drive(4'b0000, 4'b0000, 32'h0, 4'b0000);
    step();
    step();
    chk("pre_reset_busy", 64'(busy), 64'hF);
    #2;
    rst = 1'b1;
    drive(4'b1111, 4'b1111, 32'h0909_0909, 4'b1111);
    #1;
    chk("async_reset", 64'({texpired, busy, remaining}), 64'h0);
    for (int r = 0; r < 3; r++) begin
      step();
      chk("reset_hold", 64'({texpired, busy, remaining}), 64'h0);
    end
    drive(4'b0001, 4'b0000, 32'h0000_0001, 4'b0000);
    rst    = 1'b0;
    edge_n = 0;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e == 1) drive(4'b0000, 4'b0000, 32'h0, 4'b0000);
      chk("post_reset_exp", 64'(texpired[0]), 64'(e == 4));
      chk("post_reset_busy", 64'(busy[0]), 64'(e < 4));
    end

    // All four channels expire on the same tick (edge 12); ch3 starts on a tick
    do_reset();
    for (int e = 1; e <= 13; e++) begin
      case (e)
        1:       drive(4'b0001, 4'b0000, 32'h0000_0003, 4'b0000);
        4:       drive(4'b1000, 4'b0000, 32'h0200_0000, 4'b0000);
        5:       drive(4'b0010, 4'b0000, 32'h0000_0200, 4'b0000);
        9:       drive(4'b0100, 4'b0000, 32'h0001_0000, 4'b0000);
        default: drive(4'b0000, 4'b0000, 32'h0000_0000, 4'b0000);
      endcase
      step();
      if (e == 4)  chk("align_load", 64'(remaining[31:24]), 64'd2);
      if (e == 8)  chk("align_dec", 64'(remaining[31:24]), 64'd1);
      if (e == 11) chk("coinc_busy", 64'(busy), 64'hF);
      if (e == 12) chk("coinc_idle", 64'({busy, remaining}), 64'h0);
      chk("coinc_exp", 64'(texpired), (e == 12) ? 64'hF : 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
